// File: rtl/system_wrapper.sv
// ---------------------------------------------------------------------------
// system_wrapper
// Serial-link demo: a router moves one 32-bit word from a source ROM to a
// destination RAM by framing it onto the serial TX lane. The RX lane
// (looped back externally) byte-locks on the idle character, checks each
// frame and commits it to RAM.
//
// Ports
//   init_clk                     system clock, all registers on its rising edge
//   reset_pb                     synchronous active-high reset
//   pma_init                     link hold-down: drops lock, forces txp low
//   GT_REFCLK_clk_p/_n           reference clock pins (pinout only)
//   GT_SERIAL_TX_txp/_txn        serial TX, MSB first, txn = ~txp
//   GT_SERIAL_RX_rxp/_rxn        serial RX, only rxp is used
//   channel_up                   receiver byte-locked
//   router_start_req             transfer request (rising edge in IDLE)
//   router_scr_addr              source ROM word address
//   router_dst_addr              destination RAM word address
//   router_done                  one-cycle pulse on frame commit
//
// Router FSM
//   state  | meaning
//   IDLE   | waiting for a request while the link is up
//   READ   | one-cycle ROM read of the source word
//   SEND   | frame handed to TX, waiting for checksum byte to finish
//   WAIT   | waiting for RX commit / bad checksum, or 128-cycle timeout
//
// Frame: 5C | {6'b0,dst[9:8]} | dst[7:0] | data[31:24..7:0] | xor(payload)
// ---------------------------------------------------------------------------
module system_wrapper (
    input  logic       init_clk,
    input  logic       reset_pb,
    input  logic       pma_init,
    input  logic       GT_REFCLK_clk_p,
    input  logic       GT_REFCLK_clk_n,
    output logic       GT_SERIAL_TX_txp,
    output logic       GT_SERIAL_TX_txn,
    input  logic       GT_SERIAL_RX_rxp,
    input  logic       GT_SERIAL_RX_rxn,
    output logic       channel_up,
    input  logic       router_start_req,
    input  logic [9:0] router_scr_addr,
    input  logic [9:0] router_dst_addr,
    output logic       router_done
);

    localparam logic [7:0] K_IDLE = 8'hBC;
    localparam logic [7:0] K_SOF  = 8'h5C;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_SEND = 2'd2, S_WAIT = 2'd3} state_t;
    typedef enum logic [1:0] {R_HUNT = 2'd0, R_ALIGN = 2'd1, R_LOCK = 2'd2} rx_state_t;

    logic unused_pins;
    assign unused_pins = GT_REFCLK_clk_p ^ GT_REFCLK_clk_n ^ GT_SERIAL_RX_rxn;

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return 32'hC0DE_0000 + {22'd0, a};
    endfunction

    // ------------------------------------------------------------------
    // Router FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [9:0]  scr_q, dst_q;
    logic [31:0] data_q;
    logic        req_prev_q;
    logic [6:0]  timer_q, timer_d;
    logic        launch;
    logic        tx_frame_end;
    logic        send_req;
    logic        router_done_q;
    logic        rx_bad_q;

    // Rising edge only, so a held request launches a single transfer.
    assign launch = router_start_req && !req_prev_q && channel_up;

    always_ff @(posedge init_clk) begin
        if (reset_pb) begin
            state_q    <= S_IDLE;
            scr_q      <= '0;
            dst_q      <= '0;
            data_q     <= '0;
            req_prev_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_prev_q <= router_start_req;
            timer_q    <= timer_d;
            if (state_q == S_IDLE && launch) begin
                scr_q <= router_scr_addr;
                dst_q <= router_dst_addr;
            end
            if (state_q == S_READ) begin
                data_q <= rom_word(scr_q);
            end
        end
    end

    // The RX result is registered, so WAIT still sees a commit that lands
    // on the same edge as the SEND->WAIT transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch) state_d = S_READ;
            S_READ:  state_d = S_SEND;
            S_SEND:  if (tx_frame_end) state_d = S_WAIT;
            S_WAIT:  if (router_done_q || rx_bad_q || timer_q == 7'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        send_req = (state_q == S_SEND);
        timer_d  = timer_q;
        if (state_q == S_SEND) begin
            timer_d = 7'd127;
        end else if (state_q == S_WAIT && timer_q != 7'd0) begin
            timer_d = timer_q - 7'd1;
        end
    end

    // ------------------------------------------------------------------
    // TX serializer
    // ------------------------------------------------------------------
    logic [7:0] tx_shift_q;
    logic [2:0] tx_bit_q;
    logic       tx_busy_q, tx_busy_d;
    logic [2:0] tx_idx_q, tx_idx_d;
    logic [7:0] tx_next_byte;
    logic [7:0] tx_csum;
    logic       tx_boundary;

    assign tx_boundary  = (tx_bit_q == 3'd7);
    assign tx_frame_end = tx_boundary && tx_busy_q && (tx_idx_q == 3'd7);

    always_comb begin
        tx_csum = {6'b0, dst_q[9:8]} ^ dst_q[7:0] ^ data_q[31:24] ^
                  data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];
        tx_busy_d    = tx_busy_q;
        tx_idx_d     = tx_idx_q;
        tx_next_byte = K_IDLE;
        if (tx_busy_q && tx_idx_q != 3'd7) begin
            tx_idx_d = tx_idx_q + 3'd1;
        end else if (tx_busy_q) begin
            tx_busy_d = 1'b0;
            tx_idx_d  = 3'd0;
        end else if (send_req) begin
            tx_busy_d = 1'b1;
            tx_idx_d  = 3'd0;
        end
        if (tx_busy_d) begin
            case (tx_idx_d)
                3'd0:    tx_next_byte = K_SOF;
                3'd1:    tx_next_byte = {6'b0, dst_q[9:8]};
                3'd2:    tx_next_byte = dst_q[7:0];
                3'd3:    tx_next_byte = data_q[31:24];
                3'd4:    tx_next_byte = data_q[23:16];
                3'd5:    tx_next_byte = data_q[15:8];
                3'd6:    tx_next_byte = data_q[7:0];
                default: tx_next_byte = tx_csum;
            endcase
        end
    end

    always_ff @(posedge init_clk) begin
        if (reset_pb) begin
            tx_shift_q <= K_IDLE;
            tx_bit_q   <= 3'd0;
            tx_busy_q  <= 1'b0;
            tx_idx_q   <= 3'd0;
        end else if (tx_boundary) begin
            tx_shift_q <= tx_next_byte;
            tx_bit_q   <= 3'd0;
            tx_busy_q  <= tx_busy_d;
            tx_idx_q   <= tx_idx_d;
        end else begin
            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            tx_bit_q   <= tx_bit_q + 3'd1;
        end
    end

    assign GT_SERIAL_TX_txp = tx_shift_q[7] & ~pma_init;
    assign GT_SERIAL_TX_txn = ~GT_SERIAL_TX_txp;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t   rx_state_q;
    logic [7:0]  rx_win_q, rx_win_d;
    logic [2:0]  rx_bit_q;
    logic [1:0]  rx_good_q;
    logic [1:0]  rx_err_q;
    logic        rx_in_frame_q;
    logic [2:0]  rx_idx_q;
    logic [9:0]  rx_hdr_q;
    logic [31:0] rx_data_q;
    logic [7:0]  rx_csum_q;
    logic        rx_byte_stb;
    logic        rx_frame_last;
    logic        rx_commit;
    logic        rx_fail;
    logic [9:0]  dst_addr;
    logic [31:0] data_arbiter_recv;
    logic [31:0] dst_ram [0:1023];

    assign rx_win_d      = {rx_win_q[6:0], GT_SERIAL_RX_rxp};
    assign rx_byte_stb   = (rx_state_q != R_HUNT) && (rx_bit_q == 3'd7);
    assign rx_frame_last = (rx_state_q == R_LOCK) && rx_in_frame_q && rx_byte_stb &&
                           (rx_idx_q == 3'd6) && !pma_init;
    assign rx_commit     = rx_frame_last && (rx_win_d == rx_csum_q);
    assign rx_fail       = rx_frame_last && (rx_win_d != rx_csum_q);

    always_ff @(posedge init_clk) begin
        if (reset_pb) begin
            rx_state_q        <= R_HUNT;
            rx_win_q          <= '0;
            rx_bit_q          <= '0;
            rx_good_q         <= '0;
            rx_err_q          <= '0;
            rx_in_frame_q     <= 1'b0;
            rx_idx_q          <= '0;
            rx_hdr_q          <= '0;
            rx_data_q         <= '0;
            rx_csum_q         <= '0;
            router_done_q     <= 1'b0;
            rx_bad_q          <= 1'b0;
            dst_addr          <= '0;
            data_arbiter_recv <= '0;
        end else begin
            rx_win_q      <= rx_win_d;
            router_done_q <= rx_commit;
            rx_bad_q      <= rx_fail;
            if (rx_commit) begin
                dst_addr          <= rx_hdr_q;
                data_arbiter_recv <= rx_data_q;
            end
            if (pma_init) begin
                rx_state_q    <= R_HUNT;
                rx_in_frame_q <= 1'b0;
                rx_err_q      <= '0;
            end else begin
                rx_bit_q <= rx_bit_q + 3'd1;
                case (rx_state_q)
                    R_HUNT: begin
                        // The matching window itself is the first of four idles.
                        if (rx_win_d == K_IDLE) begin
                            rx_state_q <= R_ALIGN;
                            rx_bit_q   <= 3'd0;
                            rx_good_q  <= 2'd1;
                        end
                    end
                    R_ALIGN: begin
                        if (rx_byte_stb) begin
                            if (rx_win_d != K_IDLE) begin
                                rx_state_q <= R_HUNT;
                            end else if (rx_good_q == 2'd3) begin
                                rx_state_q    <= R_LOCK;
                                rx_err_q      <= '0;
                                rx_in_frame_q <= 1'b0;
                            end else begin
                                rx_good_q <= rx_good_q + 2'd1;
                            end
                        end
                    end
                    R_LOCK: begin
                        if (rx_byte_stb) begin
                            if (rx_in_frame_q) begin
                                rx_idx_q <= rx_idx_q + 3'd1;
                                if (rx_idx_q < 3'd6) rx_csum_q <= rx_csum_q ^ rx_win_d;
                                if (rx_idx_q < 3'd2) begin
                                    rx_hdr_q <= {rx_hdr_q[1:0], rx_win_d};
                                end else if (rx_idx_q < 3'd6) begin
                                    rx_data_q <= {rx_data_q[23:0], rx_win_d};
                                end
                                if (rx_idx_q == 3'd6) rx_in_frame_q <= 1'b0;
                            end else if (rx_win_d == K_SOF) begin
                                rx_in_frame_q <= 1'b1;
                                rx_idx_q      <= 3'd0;
                                rx_csum_q     <= '0;
                                rx_err_q      <= '0;
                            end else if (rx_win_d == K_IDLE) begin
                                rx_err_q <= '0;
                            end else if (rx_err_q == 2'd2) begin
                                rx_state_q <= R_HUNT;
                                rx_err_q   <= '0;
                            end else begin
                                rx_err_q <= rx_err_q + 2'd1;
                            end
                        end
                    end
                    default: rx_state_q <= R_HUNT;
                endcase
            end
        end
    end

    // RAM has no reset; a reset edge suppresses a coincident commit.
    always_ff @(posedge init_clk) begin
        if (rx_commit && !reset_pb) begin
            dst_ram[rx_hdr_q] <= rx_data_q;
        end
    end

    assign channel_up  = (rx_state_q == R_LOCK);
    assign router_done = router_done_q;

endmodule

// File: tb/tb_system_wrapper.sv
module tb_system_wrapper;

    logic       init_clk = 1'b0;
    logic       reset_pb;
    logic       pma_init;
    logic       ref_p, ref_n;
    logic       tx_p, tx_n;
    logic       rx_p, rx_n;
    logic       ch_up;
    logic       start_req;
    logic [9:0] scr, dst;
    logic       done;
    logic       flip;

    int n_vec = 0;
    int n_err = 0;
    int done_cycles = 0;

    typedef struct {
        logic [9:0]  scr;
        logic [9:0]  dst;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [5];

    always #5 init_clk = ~init_clk;

    assign ref_p = init_clk;
    assign ref_n = ~init_clk;
    assign rx_p  = tx_p ^ flip;
    assign rx_n  = ~rx_p;

    system_wrapper dut (
        .init_clk         (init_clk),
        .reset_pb         (reset_pb),
        .pma_init         (pma_init),
        .GT_REFCLK_clk_p  (ref_p),
        .GT_REFCLK_clk_n  (ref_n),
        .GT_SERIAL_TX_txp (tx_p),
        .GT_SERIAL_TX_txn (tx_n),
        .GT_SERIAL_RX_rxp (rx_p),
        .GT_SERIAL_RX_rxn (rx_n),
        .channel_up       (ch_up),
        .router_start_req (start_req),
        .router_scr_addr  (scr),
        .router_dst_addr  (dst),
        .router_done      (done)
    );

    always @(negedge init_clk) if (done) done_cycles++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_up(input string name, input int budget);
        int n;
        n = 0;
        while (!ch_up && n < budget) begin
            @(negedge init_clk);
            n++;
        end
        check(name, {31'd0, ch_up}, 32'd1);
    endtask

    // Request held for two cycles; k counts edges after the first sampled
    // request edge. flip_at/pma_at/rst_at inject a fault at edge k.
    task automatic xfer(input logic [9:0] s, input logic [9:0] d, input int flip_at,
                        input int pma_at, input int rst_at, output int lat, output int npulse);
        int d0;
        d0  = done_cycles;
        lat = 0;
        @(negedge init_clk);
        scr = s;
        dst = d;
        start_req = 1'b1;
        @(posedge init_clk);
        @(posedge init_clk);
        @(negedge init_clk);
        start_req = 1'b0;
        for (int k = 2; k <= 100; k++) begin
            flip = (k == flip_at);
            if (k == pma_at) pma_init = 1'b1;
            if (pma_at > 0 && k == pma_at + 20) pma_init = 1'b0;
            reset_pb = (k == rst_at);
            @(posedge init_clk);
            @(negedge init_clk);
            if (done && lat == 0) lat = k;
            if (k == pma_at) check("chup_after_pma", {31'd0, ch_up}, 32'd0);
            if (k == rst_at) begin
                check("chup_after_rst", {31'd0, ch_up}, 32'd0);
                check("dst_addr_after_rst", {22'd0, dut.dst_addr}, 32'd0);
                check("data_after_rst", dut.data_arbiter_recv, 32'd0);
            end
        end
        flip = 1'b0;
        reset_pb = 1'b0;
        repeat (4) @(negedge init_clk);
        npulse = done_cycles - d0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got simulation stuck expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, np;
        vecs[0] = '{10'd1,   10'd5,   32'hC0DE_0001};
        vecs[1] = '{10'd0,   10'd6,   32'hC0DE_0000};
        vecs[2] = '{10'd2,   10'd7,   32'hC0DE_0002};
        vecs[3] = '{10'd512, 10'd0,   32'hC0DE_0200};
        vecs[4] = '{10'd1023, 10'd1023, 32'hC0DE_03FF};

        reset_pb  = 1'b1;
        pma_init  = 1'b1;
        start_req = 1'b0;
        scr       = '0;
        dst       = '0;
        flip      = 1'b0;

        repeat (100) @(negedge init_clk);
        check("reset_channel_up", {31'd0, ch_up}, 32'd0);
        check("reset_router_done", {31'd0, done}, 32'd0);
        check("pma_txp_low", {31'd0, tx_p}, 32'd0);
        check("pma_txn_high", {31'd0, tx_n}, 32'd1);
        repeat (28) @(negedge init_clk);
        pma_init = 1'b0;
        repeat (256) @(negedge init_clk);
        check("reset_dst_addr", {22'd0, dut.dst_addr}, 32'd0);
        check("reset_data", dut.data_arbiter_recv, 32'd0);
        reset_pb = 1'b0;
        wait_up("lock_after_reset", 64);

        for (int i = 0; i < 5; i++) begin
            repeat (300) @(negedge init_clk);
            xfer(vecs[i].scr, vecs[i].dst, 0, 0, 0, lat, np);
            check("done_pulses", np, 32'd1);
            check("latency_le_80", {31'd0, (lat > 0 && lat <= 80)}, 32'd1);
            check("dst_addr", {22'd0, dut.dst_addr}, {22'd0, vecs[i].dst});
            check("data_recv", dut.data_arbiter_recv, vecs[i].data);
            check("ram_word", dut.dst_ram[vecs[i].dst], vecs[i].data);
        end
        check("ram5_kept", dut.dst_ram[5], 32'hC0DE_0001);
        check("txn_complement", {31'd0, tx_n}, {31'd0, ~tx_p});

        // request while the link is down
        pma_init = 1'b1;
        repeat (3) @(negedge init_clk);
        check("chup_down_pma", {31'd0, ch_up}, 32'd0);
        xfer(10'd3, 10'd9, 0, 0, 0, lat, np);
        check("down_no_done", np, 32'd0);
        check("down_dst_addr", {22'd0, dut.dst_addr}, 32'h3FF);
        check("down_data", dut.data_arbiter_recv, 32'hC0DE_03FF);
        pma_init = 1'b0;
        wait_up("relock_after_pma", 100);

        // corrupted data bit
        repeat (300) @(negedge init_clk);
        xfer(10'd3, 10'd5, 45, 0, 0, lat, np);
        check("badcsum_no_done", np, 32'd0);
        check("badcsum_dst_addr", {22'd0, dut.dst_addr}, 32'h3FF);
        check("badcsum_data", dut.data_arbiter_recv, 32'hC0DE_03FF);
        check("badcsum_ram5", dut.dst_ram[5], 32'hC0DE_0001);
        repeat (300) @(negedge init_clk);
        xfer(10'd3, 10'd5, 0, 0, 0, lat, np);
        check("retry_done", np, 32'd1);
        check("retry_dst_addr", {22'd0, dut.dst_addr}, 32'h005);
        check("retry_data", dut.data_arbiter_recv, 32'hC0DE_0003);
        check("retry_ram5", dut.dst_ram[5], 32'hC0DE_0003);

        // link hold-down mid-transfer
        repeat (300) @(negedge init_clk);
        xfer(10'd4, 10'd8, 0, 30, 0, lat, np);
        check("pma_mid_no_done", np, 32'd0);
        wait_up("relock_mid_xfer", 200);
        repeat (160) @(negedge init_clk);
        check("fsm_idle_after_timeout", {30'd0, dut.state_q}, 32'd0);
        check("pma_mid_dst_addr", {22'd0, dut.dst_addr}, 32'h005);
        xfer(10'd6, 10'd8, 0, 0, 0, lat, np);
        check("after_pma_done", np, 32'd1);
        check("after_pma_ram8", dut.dst_ram[8], 32'hC0DE_0006);

        // reset mid-frame
        repeat (300) @(negedge init_clk);
        xfer(10'd4, 10'd5, 0, 0, 40, lat, np);
        check("rst_mid_no_done", np, 32'd0);
        check("rst_mid_ram5_kept", dut.dst_ram[5], 32'hC0DE_0003);
        wait_up("relock_after_rst_mid", 100);
        repeat (50) @(negedge init_clk);
        xfer(10'd7, 10'd9, 0, 0, 0, lat, np);
        check("final_done", np, 32'd1);
        check("final_dst_addr", {22'd0, dut.dst_addr}, 32'h009);
        check("final_data", dut.data_arbiter_recv, 32'hC0DE_0007);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
